// File: rtl/srff_excitation_driver.sv
// Excitation driver for an external master-slave SR flip-flop: drives S/R toward a
// requested target, lets the flop settle, then verifies its fed-back output.
module srff_excitation_driver #(
  parameter int HOLD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       s_out,
  output logic       r_out,
  input  logic       fb_q,
  output logic       exp_q,
  output logic       done,
  output logic       err,
  input  logic       err_clr,
  output logic [7:0] tx_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  localparam logic [3:0] HOLD_M1   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_tgt, r_exp, r_synced;
  logic       r_s, r_r, r_ready, r_done, r_err;
  logic [7:0] r_tx;
  logic       w_s_nxt, w_r_nxt, w_ready_nxt, w_done_nxt;
  logic       w_accept, w_check, w_mismatch;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Until the first verified transaction the flop state is unknown, so the
  // excitation is forced toward the target instead of relying on exp_q.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = 1'b0;
    w_r_nxt     = 1'b0;
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_nxt = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = DRIVE;
          w_cnt_nxt   = HOLD_M1;
          w_ready_nxt = 1'b0;
          w_s_nxt     = in_bit  & (~r_synced | ~r_exp);
          w_r_nxt     = ~in_bit & (~r_synced |  r_exp);
        end
      end
      DRIVE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = SETTLE_M1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_s_nxt   = r_s;
          w_r_nxt   = r_r;
        end
      end
      SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = CHECK;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  assign w_check    = (r_state == CHECK);
  assign w_mismatch = w_check & (fb_q != r_tgt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 4'd0;
      r_tgt    <= 1'b0;
      r_exp    <= 1'b0;
      r_synced <= 1'b0;
      r_s      <= 1'b0;
      r_r      <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_tx     <= 8'd0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) r_tgt <= in_bit;
      if (w_check) begin
        r_exp    <= r_tgt;
        r_synced <= 1'b1;
        r_tx     <= r_tx + 8'd1;
      end
      // A mismatch in the same cycle as a clear keeps the flag set.
      if (w_mismatch)   r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign in_ready = r_ready;
  assign s_out    = r_s;
  assign r_out    = r_r;
  assign exp_q    = r_exp;
  assign done     = r_done;
  assign err      = r_err;
  assign tx_count = r_tx;

endmodule

// File: tb/tb_srff_excitation_driver.sv
// Bench for srff_excitation_driver: directed vector table, then randomized traffic
// against a transaction-age reference model with a simulated SR flop on fb_q.
module tb_srff_excitation_driver;
  localparam int H = 2;
  localparam int S = 2;
  localparam int CHK_AGE = H + S + 1;

  logic       clk, rst, in_valid, in_bit, in_ready, s_out, r_out;
  logic       fb_q, exp_q, done, err, err_clr;
  logic [7:0] tx_count;

  srff_excitation_driver #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .s_out(s_out), .r_out(r_out), .fb_q(fb_q), .exp_q(exp_q), .done(done),
    .err(err), .err_clr(err_clr), .tx_count(tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rs, iv, ib, fb, ec;
    logic rdy, s, r, dn, eq, er;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int         m_age;
  logic       m_tgt, m_exp, m_synced, m_err, m_es, m_er;
  logic [7:0] m_cnt;
  int         m_ndone;
  logic       plant_q;
  logic       pre_s, pre_r, pre_rdy;

  task automatic add(input logic rs, iv, ib, fb, ec, rdy, s, r, dn, eq, er,
                     input logic [7:0] cnt);
    vec_t v;
    v.rs = rs; v.iv = iv; v.ib = ib; v.fb = fb; v.ec = ec;
    v.rdy = rdy; v.s = s; v.r = r; v.dn = dn; v.eq = eq; v.er = er; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got rdy,s,r,done,expq,err,cnt=%b want %b", name, got, want);
    end
  endtask

  function automatic logic [13:0] dut_vec();
    return {in_ready, s_out, r_out, done, exp_q, err, tx_count};
  endfunction

  function automatic logic [13:0] model_vec();
    logic s, r;
    s = (m_age >= 1 && m_age <= H) ? m_es : 1'b0;
    r = (m_age >= 1 && m_age <= H) ? m_er : 1'b0;
    return {(m_age == 0), s, r, (m_age == CHK_AGE), m_exp, m_err, m_cnt};
  endfunction

  task automatic model_edge(input logic rs, iv, ib, fb, ec);
    logic mis;
    mis = (m_age == CHK_AGE) && (fb != m_tgt);
    if (rs) begin
      m_age = 0; m_exp = 0; m_synced = 0; m_err = 0; m_cnt = 8'd0;
    end else begin
      m_err = mis ? 1'b1 : (ec ? 1'b0 : m_err);
      if (m_age == 0) begin
        if (iv) begin
          m_tgt = ib;
          m_es  = ib  && (!m_synced || !m_exp);
          m_er  = !ib && (!m_synced ||  m_exp);
          m_age = 1;
        end
      end else if (m_age == CHK_AGE) begin
        m_exp = m_tgt; m_synced = 1; m_cnt = m_cnt + 8'd1; m_age = 0; m_ndone++;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic step(input logic rs_i, iv_i, ib_i, fb_i, ec_i);
    rst = rs_i; in_valid = iv_i; in_bit = ib_i; fb_q = fb_i; err_clr = ec_i;
    pre_s = s_out; pre_r = r_out; pre_rdy = in_ready;
    @(posedge clk);
    if (pre_s === 1'b1)      plant_q = 1'b1;
    else if (pre_r === 1'b1) plant_q = 1'b0;
    model_edge(rs_i, iv_i, ib_i, fb_i, ec_i);
    #1;
  endtask

  task automatic model_step(input string name, input logic rs_i, iv_i, ib_i, fb_i, ec_i);
    step(rs_i, iv_i, ib_i, fb_i, ec_i);
    chk(name, dut_vec(), model_vec());
    n_tests++;
    if ((s_out & r_out) !== 1'b0) begin
      n_fail++;
      $display("FAIL s_and_r: got s=%b r=%b want not both 1", s_out, r_out);
    end
  endtask

  initial begin
    int last_acc, n_acc, budget;
    rst = 0; in_valid = 0; in_bit = 0; fb_q = 0; err_clr = 0;
    plant_q = 0; m_age = 0; m_exp = 0; m_synced = 0; m_err = 0; m_cnt = 0;
    m_tgt = 0; m_es = 0; m_er = 0; m_ndone = 0;

    //   rs iv ib fb ec | rdy s  r  dn eq er cnt
    add(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);  // reset state
    add(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);  // unsynced: target 0 forces R
    add(0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);  // done at T+5
    add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0, 1);  // set
    add(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0,   1, 0, 0, 0, 1, 0, 2);
    add(0, 1, 1, 1, 0,   0, 0, 0, 0, 1, 0, 2);  // same target: hold
    add(0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2);  // in_valid ignored while busy
    add(0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2);
    add(0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2);
    add(0, 1, 0, 1, 0,   0, 0, 0, 1, 1, 0, 2);
    add(0, 1, 0, 1, 0,   1, 0, 0, 0, 1, 0, 3);
    add(0, 1, 0, 1, 0,   0, 0, 1, 0, 1, 0, 3);  // reset toward 0
    add(0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 0, 3);
    add(0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 4);
    add(0, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0, 4);  // stuck-at-0 feedback
    add(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1, 5);  // err at T+6
    add(0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1, 5);  // sticky
    add(0, 1, 0, 0, 0,   0, 0, 1, 0, 1, 1, 5);
    add(0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 1, 5);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 5);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 5);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 1, 5);
    add(0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 1, 6);  // mismatch beats clear
    add(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 6);  // clear alone
    add(0, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0, 6);
    add(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 6);
    add(1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0);  // abort mid-DRIVE
    add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);  // no done pulse
    add(0, 1, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0);  // unsynced again after reset

    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].iv, tbl[i].ib, tbl[i].fb, tbl[i].ec);
      chk($sformatf("vec%0d", i), dut_vec(),
          {tbl[i].rdy, tbl[i].s, tbl[i].r, tbl[i].dn, tbl[i].eq, tbl[i].er, tbl[i].cnt});
    end

    // 256 back-to-back transactions with in_valid held: wrap and accept spacing
    model_step("wrap_rst", 1, 0, 0, plant_q, 0);
    m_ndone = 0; last_acc = -1; n_acc = 0; budget = 0;
    while (m_ndone < 256 && budget < 2000) begin
      model_step("wrap", 0, 1, 1'($urandom_range(1)), plant_q, 0);
      if (pre_rdy === 1'b1) begin
        if (last_acc >= 0) begin
          n_tests++;
          if (budget - last_acc != H + S + 2) begin
            n_fail++;
            $display("FAIL accept_gap: got %0d want %0d", budget - last_acc, H + S + 2);
          end
        end
        last_acc = budget; n_acc++;
      end
      budget++;
    end
    n_tests++;
    if (m_ndone < 256 || tx_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_count: got dones=%0d tx_count=%0d want 256 and 0", m_ndone, tx_count);
    end

    // fully random traffic, occasional feedback faults, clears and resets
    for (int i = 0; i < 2500; i++) begin
      logic fb;
      fb = ($urandom_range(4) == 0) ? 1'($urandom_range(1)) : plant_q;
      model_step("rand", ($urandom_range(63) == 0), ($urandom_range(2) != 0),
                 1'($urandom_range(1)), fb, ($urandom_range(9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/srff_excitation_driver.md
SRFF_EXCITATION_DRIVER -- requirements
Module: srff_excitation_driver

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2: number of cycles S/R excitation is held asserted (legal range 1..15).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: number of cycles both S and R are held low before feedback is checked (legal range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  a target bit is offered.
REQ-006 SHALL have port in_bit  input  1  the target value for the flip-flop output.
REQ-007 SHALL have port in_ready  output  1  the driver accepts a target this cycle.
REQ-008 SHALL have port s_out  output  1  set excitation to the master-slave SR flip-flop.
REQ-009 SHALL have port r_out  output  1  reset excitation to the master-slave SR flip-flop.
REQ-010 SHALL have port fb_q  input  1  flip-flop slave output fed back.
REQ-011 SHALL have port exp_q  output  1  the driver's model of the flip-flop state.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking completion of a transaction.
REQ-013 SHALL have port err  output  1  sticky mismatch flag.
REQ-014 SHALL have port err_clr  input  1  clears err.
REQ-015 SHALL have port tx_count  output  8  count of completed transactions.

Function
REQ-016 SHALL implement states IDLE, DRIVE, SETTLE, CHECK; all outputs registered.
REQ-017 IDLE: in_ready=1, s_out=r_out=0; in_valid&in_ready at edge T captures in_bit as tgt and moves to DRIVE.
REQ-018 SHALL derive excitation from exp_q and tgt: tgt=1 and exp_q=0 -> S=1,R=0; tgt=0 and exp_q=1 -> S=0,R=1; tgt==exp_q -> S=0,R=0 (hold).
REQ-019 SHALL use the following override while the internal flag synced=0: tgt=1 -> S=1,R=0 and tgt=0 -> S=0,R=1, regardless of exp_q.
REQ-020 DRIVE: s_out/r_out SHALL hold the derived values for cycles T+1..T+HOLD_CYCLES, with in_ready=0.
REQ-021 SETTLE: s_out=r_out=0 for cycles T+HOLD_CYCLES+1..T+HOLD_CYCLES+SETTLE_CYCLES.
REQ-022 CHECK: in cycle T+HOLD_CYCLES+SETTLE_CYCLES+1, done=1; fb_q is compared with tgt; exp_q<=tgt; synced<=1; tx_count increments.
REQ-023 SHALL return to IDLE after CHECK; in_ready=1 from cycle T+HOLD_CYCLES+SETTLE_CYCLES+2 (default: done at T+5, ready at T+6).
REQ-024 SHALL set err on fb_q!=tgt in CHECK; err stays 1 until err_clr or rst.
REQ-025 If err_clr is asserted in the same cycle as a CHECK mismatch, set SHALL win and err stays 1.
REQ-026 SHALL never assert s_out and r_out simultaneously (forbidden 11 input), in any state or cycle.
REQ-027 SHALL ignore in_valid outside IDLE; no transaction is queued.
REQ-028 tx_count SHALL wrap 255 -> 0 without side effects.
REQ-029 SHALL ignore fb_q outside the CHECK cycle.

Reset
REQ-030 rst SHALL force at the next edge: state=IDLE, s_out=r_out=0, in_ready=1, exp_q=0, synced=0, done=0, err=0, tx_count=0.
REQ-031 rst asserted mid-DRIVE or mid-SETTLE SHALL abort the transaction: no done, no tx_count increment, excitation deasserted the following cycle.
REQ-032 rst SHALL take priority over in_valid, err_clr and CHECK updates in the same cycle.

Verification
REQ-033 After reset, send in_bit=0 with fb_q model following the FF -> r_out=1 for 2 cycles (forced by synced=0), done at T+5, err=0, exp_q=0, tx_count=1.
REQ-034 From exp_q=0, send 1 -> s_out=1 at T+1,T+2; send 1 again -> s_out=r_out=0 throughout, done at T+5, err=0; send 0 -> r_out=1 for 2 cycles.
REQ-035 Hold fb_q=0 stuck, send 1 -> err=1 at T+6 and stays 1; assert err_clr in the next mismatch CHECK cycle -> err stays 1; assert err_clr alone -> err=0.
REQ-036 Assert rst at T+2 of a transaction -> s_out=r_out=0 next cycle, in_ready=1, tx_count=0, no done pulse.
REQ-037 Run 256 transactions -> tx_count=0 after the 256th done; check s_out&r_out==0 on every cycle.
REQ-038 Hold in_valid=1 continuously -> one accept per 6 cycles at default parameters; targets offered while in_ready=0 are not captured.
